// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // Bus transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // RV32I load/store funct3 encodings (stores use only B/H/W).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: shifts the addressed byte/half down to
// bit 0 and sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;

    // Bring the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        w_shifted = i_rdata >> {i_byte_off, 3'b000};
        case (i_funct3)
            F3_B:    o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_result = {24'd0, w_shifted[7:0]};
            F3_HU:   o_result = {16'd0, w_shifted[15:0]};
            default: o_result = i_rdata;    // LW: word passes through
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: converts a load/store into one valid/ready
// data-bus transaction, stalls the pipeline while it is outstanding, and
// registers the aligned load result for writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] rdata3,
    output logic          access_err,
    output logic          dbus_req_valid,
    input  logic          dbus_req_ready,
    output logic          dbus_we,
    output logic [DW-1:0] dbus_addr,
    output logic [3:0]    dbus_wstrb,
    output logic [DW-1:0] dbus_wdata,
    input  logic          dbus_rsp_valid,
    input  logic [DW-1:0] dbus_rdata
);

    lsu_state_e    r_state;
    lsu_state_e    w_state_next;

    logic          w_access;
    logic          w_f3_illegal;
    logic          w_misaligned;
    logic          w_legal;
    logic [3:0]    w_strb;
    logic [DW-1:0] w_lane_data;
    logic [DW-1:0] w_load_result;

    logic [DW-1:0] r_addr;
    logic [2:0]    r_funct3;
    logic          r_we;
    logic [3:0]    r_wstrb;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata3;
    logic          r_access_err;

    // Classify the presented access: illegal encoding or misaligned address.
    always_comb begin
        w_access     = mem_rd | mem_wr;
        w_f3_illegal = mem_wr ? (funct3 > F3_W)
                              : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
        case (funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = (addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_legal = w_access & ~w_f3_illegal & ~w_misaligned;
    end

    // Store byte strobes and lane-replicated data; loads never write.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << addr[1:0];
                w_lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << {addr[1], 1'b0};
                w_lane_data = {2{wdata[15:0]}};
            end
            default: begin
                w_strb      = 4'b1111;
                w_lane_data = wdata;
            end
        endcase
        if (!mem_wr) begin
            w_strb      = 4'b0000;
            w_lane_data = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state plus the combinational stall and request-valid outputs.
    always_comb begin
        w_state_next   = r_state;
        stall          = 1'b0;
        dbus_req_valid = 1'b0;
        case (r_state)
            IDLE: begin
                stall = w_legal;
                if (w_legal) w_state_next = REQ;
            end
            REQ: begin
                stall          = 1'b1;
                dbus_req_valid = 1'b1;
                if (dbus_req_ready) w_state_next = r_we ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (dbus_rsp_valid) w_state_next = DONE;
            end
            DONE: begin
                // One unstalled cycle lets the instruction leave MEM; the
                // same instruction is still on the inputs, so it is ignored.
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Capture registers, load result and the registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_funct3     <= 3'd0;
            r_we         <= 1'b0;
            r_wstrb      <= 4'd0;
            r_wdata      <= '0;
            r_rdata3     <= '0;
            r_access_err <= 1'b0;
        end else begin
            r_access_err <= (r_state == IDLE) && w_access && !w_legal;
            if (r_state == IDLE && w_legal) begin
                r_addr   <= addr;
                r_funct3 <= funct3;
                r_we     <= mem_wr;
                r_wstrb  <= w_strb;
                r_wdata  <= w_lane_data;
            end
            if (r_state == WAIT && dbus_rsp_valid) begin
                r_rdata3 <= w_load_result;
            end
        end
    end

    load_align u_load_align (
        .i_rdata    (dbus_rdata),
        .i_byte_off (r_addr[1:0]),
        .i_funct3   (r_funct3),
        .o_result   (w_load_result)
    );

    assign dbus_addr  = {r_addr[DW-1:2], 2'b00};
    assign dbus_we    = r_we;
    assign dbus_wstrb = r_wstrb;
    assign dbus_wdata = r_wdata;
    assign rdata3     = r_rdata3;
    assign access_err = r_access_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a scoreboard queue
// of expected load results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] rdata3;
    logic        access_err;
    logic        dbus_req_valid, dbus_req_ready, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_rsp_valid;
    logic [31:0] dbus_rdata;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rdata3 = 32'd0;

    load_store_unit #(.DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .stall          (stall),
        .rdata3         (rdata3),
        .access_err     (access_err),
        .dbus_req_valid (dbus_req_valid),
        .dbus_req_ready (dbus_req_ready),
        .dbus_we        (dbus_we),
        .dbus_addr      (dbus_addr),
        .dbus_wstrb     (dbus_wstrb),
        .dbus_wdata     (dbus_wdata),
        .dbus_rsp_valid (dbus_rsp_valid),
        .dbus_rdata     (dbus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One legal access from presentation through DONE and back to idle.
    task automatic do_access(input string tag, input logic is_ld, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int rdy_delay,
                             input logic [31:0] rsp_word, input logic [31:0] exp_rd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input int exp_stall);
        int   stall_cnt = 0;
        int   req_cyc   = 0;
        int   cyc       = 0;
        logic accepted  = 1'b0;
        logic [31:0] exp_q;
        @(negedge clk);
        mem_rd = is_ld; mem_wr = !is_ld; funct3 = f3; addr = a; wdata = wd;
        dbus_req_ready = (rdy_delay == 0);
        if (is_ld) sb_q.push_back(exp_rd);
        #1;
        while (stall && cyc < 40) begin
            stall_cnt++;
            if (dbus_req_valid) begin
                req_cyc++;
                check({tag, " addr"}, dbus_addr, exp_addr);
                check({tag, " wstrb"}, 32'(dbus_wstrb), 32'(exp_strb));
                check({tag, " we"}, 32'(dbus_we), 32'(!is_ld));
                if (!is_ld) check({tag, " wdata"}, dbus_wdata, exp_wdata);
                dbus_req_ready = (req_cyc > rdy_delay);
                if (dbus_req_ready) accepted = 1'b1;
            end else if (accepted && is_ld) begin
                dbus_rsp_valid = 1'b1;
                dbus_rdata     = rsp_word;
            end
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, " finished"}, 32'(cyc < 40), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " valid in DONE"}, 32'(dbus_req_valid), 32'd0);
        check({tag, " access_err"}, 32'(access_err), 32'd0);
        if (is_ld) begin
            exp_q = sb_q.pop_front();
            check({tag, " rdata3"}, rdata3, exp_q);
            last_rdata3 = exp_q;
        end else begin
            check({tag, " rdata3 kept"}, rdata3, last_rdata3);
        end
        dbus_rsp_valid = 1'b0; dbus_rdata = 32'd0; dbus_req_ready = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk); #1;
        check({tag, " idle stall"}, 32'(stall), 32'd0);
        $display("%s: %s addr=%h stall_cycles=%0d rdata3=%h", tag, is_ld ? "load" : "store",
                 a, stall_cnt, rdata3);
    endtask

    // A misaligned or illegal access: no bus traffic, one-cycle error pulse.
    task automatic do_err(input string tag, input logic is_ld, input logic [2:0] f3,
                          input logic [31:0] a);
        @(negedge clk);
        mem_rd = is_ld; mem_wr = !is_ld; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
        dbus_req_ready = 1'b1;
        #1;
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " no req"}, 32'(dbus_req_valid), 32'd0);
        check({tag, " err before"}, 32'(access_err), 32'd0);
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; dbus_req_ready = 1'b0;
        @(negedge clk); #1;
        check({tag, " err pulse"}, 32'(access_err), 32'd1);
        check({tag, " no req after"}, 32'(dbus_req_valid), 32'd0);
        @(negedge clk); #1;
        check({tag, " err cleared"}, 32'(access_err), 32'd0);
        $display("%s: faulting access addr=%h funct3=%b", tag, a, f3);
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst req_valid", 32'(dbus_req_valid), 32'd0);
        check("rst we", 32'(dbus_we), 32'd0);
        check("rst wstrb", 32'(dbus_wstrb), 32'd0);
        check("rst addr", dbus_addr, 32'd0);
        check("rst wdata", dbus_wdata, 32'd0);
        check("rst rdata3", rdata3, 32'd0);
        check("rst access_err", 32'(access_err), 32'd0);
        $display("reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        //        tag     ld    f3      addr          wdata         dly rsp          exp_rd        exp_addr      strb     exp_wdata     stall
        do_access("LW",   1'b1, 3'b010, 32'h0000_0100, 32'd0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0100, 4'b0000, 32'd0,        3);
        do_access("LB",   1'b1, 3'b000, 32'h0000_0103, 32'd0,        0, 32'h80FF0000, 32'hFFFFFF80, 32'h0000_0100, 4'b0000, 32'd0,        3);
        do_access("LBU",  1'b1, 3'b100, 32'h0000_0103, 32'd0,        0, 32'h80FF0000, 32'h00000080, 32'h0000_0100, 4'b0000, 32'd0,        3);
        do_access("LH",   1'b1, 3'b001, 32'h0000_0102, 32'd0,        0, 32'h80FF0000, 32'hFFFF80FF, 32'h0000_0100, 4'b0000, 32'd0,        3);
        do_access("LHU",  1'b1, 3'b101, 32'h0000_0102, 32'd0,        0, 32'h80FF0000, 32'h000080FF, 32'h0000_0100, 4'b0000, 32'd0,        3);
        do_access("LB1",  1'b1, 3'b000, 32'h0000_0101, 32'd0,        1, 32'h12345678, 32'h00000056, 32'h0000_0100, 4'b0000, 32'd0,        4);
        do_access("SH",   1'b0, 3'b001, 32'h0000_0202, 32'h1234ABCD, 0, 32'd0,        32'd0,        32'h0000_0200, 4'b1100, 32'hABCDABCD, 2);
        do_access("SH0",  1'b0, 3'b001, 32'h0000_0200, 32'h00001111, 0, 32'd0,        32'd0,        32'h0000_0200, 4'b0011, 32'h11111111, 2);
        do_access("SB",   1'b0, 3'b000, 32'h0000_0201, 32'h0000005A, 0, 32'd0,        32'd0,        32'h0000_0200, 4'b0010, 32'h5A5A5A5A, 2);
        do_access("SWrdy",1'b0, 3'b010, 32'h0000_0300, 32'hA5A50F0F, 3, 32'd0,        32'd0,        32'h0000_0300, 4'b1111, 32'hA5A50F0F, 5);

        do_err("LWmis",  1'b1, 3'b010, 32'h0000_0102);
        do_err("LD011",  1'b1, 3'b011, 32'h0000_0100);
        do_err("LHUmis", 1'b1, 3'b101, 32'h0000_0101);
        do_err("SHmis",  1'b0, 3'b001, 32'h0000_0201);
        do_err("ST100",  1'b0, 3'b100, 32'h0000_0200);

        // Reset while the request is pending in REQ.
        @(negedge clk);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400; dbus_req_ready = 1'b0;
        @(negedge clk); #1;
        check("rstREQ valid before", 32'(dbus_req_valid), 32'd1);
        mem_rd = 1'b0;
        rst = 1'b1;
        #1;
        check("rstREQ valid", 32'(dbus_req_valid), 32'd0);
        check("rstREQ stall", 32'(stall), 32'd0);
        check("rstREQ rdata3", rdata3, 32'd0);
        $display("rstREQ: reset during request");
        @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for the load response; the late response is dropped.
        @(negedge clk);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500; dbus_req_ready = 1'b1;
        @(negedge clk); #1;
        check("rstWAIT req", 32'(dbus_req_valid), 32'd1);
        @(negedge clk); #1;
        check("rstWAIT in wait", 32'(stall), 32'd1);
        mem_rd = 1'b0; dbus_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rstWAIT valid", 32'(dbus_req_valid), 32'd0);
        check("rstWAIT stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dbus_rsp_valid = 1'b1; dbus_rdata = 32'hCAFEF00D;
        @(negedge clk); #1;
        dbus_rsp_valid = 1'b0; dbus_rdata = 32'd0;
        check("rstWAIT late rsp rdata3", rdata3, 32'd0);
        check("rstWAIT late rsp stall", 32'(stall), 32'd0);
        last_rdata3 = 32'd0;
        $display("rstWAIT: reset during wait, late response ignored");

        do_access("LWpost", 1'b1, 3'b010, 32'h0000_0600, 32'd0, 0, 32'h13579BDF, 32'h13579BDF,
                  32'h0000_0600, 4'b0000, 32'd0, 3);

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the pipelined RV32I core. Turns the MEM-stage load/store into a valid/ready data-bus transaction, drives byte strobes and replicated store data, and aligns plus sign/zero-extends returned load data into `rdata3`, which the writeback select passes to the register file. The unit stalls the pipeline while a bus access is outstanding.

## Interface
Parameters:
- `DW`, 32, data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  Clock. All state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `mem_rd`  in  1  MEM-stage instruction is a load.
- `mem_wr`  in  1  MEM-stage instruction is a store. Never asserted together with `mem_rd`.
- `funct3`  in  3  Access size and signedness, from the instruction.
- `addr`  in  32  Effective byte address (ALU result).
- `wdata`  in  32  Store source (rs2 value).
- `stall`  out  1  Hold the PC and the IF/ID/EX/MEM pipeline registers.
- `rdata3`  out  32  Aligned and extended load result, for writeback.
- `access_err`  out  1  One-cycle pulse for a misaligned access or an illegal `funct3`.
- `dbus_req_valid`  out  1  Request valid.
- `dbus_req_ready`  in  1  Memory accepts the request.
- `dbus_we`  out  1  1 = store, 0 = load.
- `dbus_addr`  out  32  Word address, `{addr[31:2],2'b00}`.
- `dbus_wstrb`  out  4  Byte-lane write strobes. 0000 for loads.
- `dbus_wdata`  out  32  Lane-replicated store data.
- `dbus_rsp_valid`  in  1  Load data valid.
- `dbus_rdata`  in  32  Load data word.

## Operation
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - An access is `mem_rd | mem_wr`.
  - If the access is legal, capture `addr`, `funct3`, the access type and the store lanes, then go to REQ.
  - If the access is misaligned or illegal, do not go to the bus. Set `access_err` for the next cycle and stay in IDLE.
- REQ:
  - `dbus_req_valid` = 1. The address, strobe and data outputs are driven from the captured registers and stay stable until the handshake.
  - On `valid & ready`, a store goes to DONE and a load goes to WAIT.
- WAIT: on `dbus_rsp_valid`, register the aligned result into `rdata3`, then go to DONE.
- DONE:
  - `stall` = 0 for exactly one cycle, so the instruction advances.
  - Inputs are ignored in this cycle, because the same instruction is still presented.
  - Next state is IDLE.
- `stall` = (IDLE & legal access) | REQ | WAIT. In IDLE the term is combinational from the inputs.
- Misaligned: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
- Illegal `funct3`: loads with 011, 110 or 111; stores with anything above 010.
- Store lanes:
  - SB: strobe `0001<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: strobe `0011<<{addr[1],1'b0}`, data `{2{wdata[15:0]}}`.
  - SW: strobe 1111, data `wdata`.
- Load extract:
  - Byte select is `rdata>>(8*addr[1:0])`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- `rdata3` holds its value until the next load completes.
- `dbus_rsp_valid` is ignored outside WAIT. `dbus_req_ready` is ignored outside REQ.

## Timing
- Reset values: state IDLE; `dbus_req_valid`, `dbus_we`, `dbus_wstrb` = 0; `dbus_addr`, `dbus_wdata`, `rdata3` = 0; `access_err` = 0.
- Reset mid-transaction abandons the access. `dbus_req_valid` drops asynchronously.
- Minimum latency with ready=1 and a response one cycle after accept:
  - Load: 4 cycles (IDLE→REQ→WAIT→DONE), `stall` high for 3 cycles.
  - Store: 3 cycles, `stall` high for 2 cycles.
- The memory returns a response no earlier than the cycle after accept.
- Only one transaction is outstanding at a time.
- `access_err` is registered, so it is high in the cycle after the faulting access is presented.

## Structure
- `lsu_pkg` holds:
  - the `lsu_state_e` enum;
  - `funct3` localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module `load_align` is combinational. It takes `rdata`, `addr[1:0]` and `funct3`, and produces the extended 32-bit result.
- The FSM, the capture registers and the store-lane logic live in the top level.

## Test plan
- LW from 0x100, ready=1, `rdata`=0xDEADBEEF one cycle after accept → `dbus_addr`=0x100, `stall` high for 3 cycles, `rdata3`=0xDEADBEEF in DONE.
- LB from 0x103 with `rdata`=0x80FF_0000 → `rdata3`=0xFFFFFF80. LBU, same case → 0x00000080.
- SH to 0x202, `wdata`=0x1234ABCD → `dbus_wstrb`=1100, `dbus_wdata`=0xABCDABCD, `dbus_we`=1, no `rdata3` change.
- SW with ready low for 3 cycles → `dbus_req_valid`, `dbus_addr` and `dbus_wdata` held constant, `stall` high until the handshake, then one DONE cycle.
- LW at 0x102 → no `dbus_req_valid`, `access_err` pulse for 1 cycle, `stall`=0. LOAD with `funct3`=011 → same response.
- `rst` asserted in WAIT → `dbus_req_valid`=0 and state IDLE immediately. A late `dbus_rsp_valid` leaves `rdata3`=0.
